// File: rtl/fb_window_streamer_pkg.sv
// Shared types and constants for the frame-buffer window streamer.
package fb_stream_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR     = 3'd1,
        FETCH   = 3'd2,
        WAIT_RD = 3'd3,
        SEND_PX = 3'd4,
        CKSUM   = 3'd5,
        DONE    = 3'd6
    } fbs_state_t;

    localparam int         HDR_BYTES     = 5;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

    // Header bytes after the sync marker: width then height, little-endian.
    function automatic logic [7:0] hdr_byte(input logic [2:0] idx,
                                            input logic [15:0] w,
                                            input logic [15:0] h);
        case (idx)
            3'd1:    return w[7:0];
            3'd2:    return w[15:8];
            3'd3:    return h[7:0];
            3'd4:    return h[15:8];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/fb_window_addr_gen.sv
// Walks the window row-major and produces frame-buffer read addresses.
// Only the row origin product is formed at load; stepping uses adds.
module fb_window_addr_gen #(
    parameter int H_RES  = 1920,
    parameter int ADDR_W = 21
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [15:0]       win_x_i,
    input  logic [15:0]       win_y_i,
    input  logic [15:0]       win_w_i,
    input  logic [15:0]       win_h_i,
    output logic [ADDR_W-1:0] fb_addr_o,
    output logic              last_px_o
);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    logic [15:0]       col_q, col_d, row_q, row_d, x_q, x_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic              col_last;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        row_base_d = row_base_q;
        col_last   = (col_q == win_w_i - 16'd1);
        if (load_i) begin
            col_d      = 16'd0;
            row_d      = 16'd0;
            x_d        = win_x_i;
            row_base_d = ADDR_W'(win_y_i) * H_RES_A;
        end else if (step_i) begin
            if (col_last) begin
                col_d      = 16'd0;
                row_d      = row_q + 16'd1;
                row_base_d = row_base_q + H_RES_A;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q      <= '0;
            row_q      <= '0;
            x_q        <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            x_q        <= x_d;
            row_base_q <= row_base_d;
        end
    end

    assign fb_addr_o = row_base_q + ADDR_W'(x_q) + ADDR_W'(col_q);
    assign last_px_o = col_last && (row_q == win_h_i - 16'd1);

endmodule

// File: rtl/fb_window_streamer.sv
// Streams a frame-buffer window to the UART as sync, header, pixels, checksum.
//   state   | meaning
//   IDLE    | waiting for start; bad windows pulse err
//   HDR     | sync + 4 size bytes, one outstanding at a time
//   FETCH   | fb_rd strobe for the current pixel
//   WAIT_RD | count down read latency, capture pixel
//   SEND_PX | shift pixel bytes out MSB-first
//   CKSUM   | send sum of pixel bytes
//   DONE    | done pulse, back to IDLE
module fb_window_streamer
    import fb_stream_pkg::*;
#(
    parameter int         H_RES        = 1920,
    parameter int         V_RES        = 1080,
    parameter int         BYTES_PER_PX = 3,
    parameter int         FB_LATENCY   = 1,
    parameter int         ADDR_W       = $clog2(H_RES*V_RES),
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [15:0]               win_x_i,
    input  logic [15:0]               win_y_i,
    input  logic [15:0]               win_w_i,
    input  logic [15:0]               win_h_i,
    output logic                      fb_rd_o,
    output logic [ADDR_W-1:0]         fb_addr_o,
    input  logic [8*BYTES_PER_PX-1:0] fb_rdata_i,
    output logic [7:0]                tx_data_o,
    output logic                      trmt_o,
    input  logic                      tx_done_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o
);
    localparam int         PX_W     = 8*BYTES_PER_PX;
    localparam logic [2:0] LAST_HDR = 3'(HDR_BYTES-1);
    localparam logic [2:0] LAST_PXB = 3'(BYTES_PER_PX-1);
    localparam logic [1:0] LAT_INIT = 2'(FB_LATENCY-1);

    fbs_state_t        state_q, state_d;
    logic [15:0]       w_q, w_d, h_q, h_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [PX_W-1:0]   shift_q, shift_d;
    logic [7:0]        cksum_q, cksum_d, tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d, err_q, err_d;
    logic              load, step, last_px, win_ok;
    logic [16:0]       x_end, y_end;

    fb_window_addr_gen #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (load),
        .step_i    (step),
        .win_x_i   (win_x_i),
        .win_y_i   (win_y_i),
        .win_w_i   (w_q),
        .win_h_i   (h_q),
        .fb_addr_o (fb_addr_o),
        .last_px_o (last_px)
    );

    always_comb begin
        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        shift_d    = shift_q;
        cksum_d    = cksum_q;
        tx_data_d  = tx_data_q;
        trmt_d     = 1'b0;
        err_d      = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        x_end      = {1'b0, win_x_i} + {1'b0, win_w_i};
        y_end      = {1'b0, win_y_i} + {1'b0, win_h_i};
        win_ok     = (x_end <= 17'(H_RES)) && (y_end <= 17'(V_RES));

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (win_ok) begin
                        state_d    = HDR;
                        w_d        = win_w_i;
                        h_d        = win_h_i;
                        byte_cnt_d = 3'd0;
                        cksum_d    = 8'd0;
                        tx_data_d  = SYNC_BYTE;
                        trmt_d     = 1'b1;
                        load       = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            HDR: begin
                if (tx_done_i) begin
                    if (abort_i) begin
                        state_d = DONE;
                    end else if (byte_cnt_q == LAST_HDR) begin
                        if (w_q == 16'd0 || h_q == 16'd0) begin
                            state_d   = CKSUM;
                            tx_data_d = cksum_q;
                            trmt_d    = 1'b1;
                        end else begin
                            state_d = FETCH;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tx_data_d  = hdr_byte(byte_cnt_q + 3'd1, w_q, h_q);
                        trmt_d     = 1'b1;
                    end
                end
            end
            // No byte is outstanding here, so abort takes effect at once.
            FETCH: begin
                if (abort_i) begin
                    state_d = DONE;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (abort_i) begin
                    state_d = DONE;
                end else if (lat_cnt_q == 2'd0) begin
                    shift_d    = fb_rdata_i;
                    tx_data_d  = fb_rdata_i[PX_W-1 -: 8];
                    cksum_d    = cksum_q + tx_data_d;
                    byte_cnt_d = 3'd0;
                    trmt_d     = 1'b1;
                    state_d    = SEND_PX;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            SEND_PX: begin
                if (tx_done_i) begin
                    if (abort_i) begin
                        state_d = DONE;
                    end else if (byte_cnt_q == LAST_PXB) begin
                        if (last_px) begin
                            state_d   = CKSUM;
                            tx_data_d = cksum_q;
                            trmt_d    = 1'b1;
                        end else begin
                            step    = 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        shift_d    = shift_q << 8;
                        tx_data_d  = shift_d[PX_W-1 -: 8];
                        cksum_d    = cksum_q + tx_data_d;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        trmt_d     = 1'b1;
                    end
                end
            end
            CKSUM: begin
                if (tx_done_i) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            w_q        <= '0;
            h_q        <= '0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            shift_q    <= '0;
            cksum_q    <= '0;
            tx_data_q  <= '0;
            trmt_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            byte_cnt_q <= byte_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            shift_q    <= shift_d;
            cksum_q    <= cksum_d;
            tx_data_q  <= tx_data_d;
            trmt_q     <= trmt_d;
            err_q      <= err_d;
        end
    end

    assign fb_rd_o   = (state_q == FETCH);
    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign trmt_o    = trmt_q;
    assign tx_data_o = tx_data_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_fb_window_streamer.sv
// Directed bench for fb_window_streamer with a 3-cycle frame-buffer read latency.
module tb_fb_window_streamer;
    localparam int H_RES  = 1920;
    localparam int V_RES  = 1080;
    localparam int BPP    = 3;
    localparam int LAT    = 3;
    localparam int ADDR_W = $clog2(H_RES*V_RES);
    localparam int D      = 10;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0, tx_done_i = 1'b0;
    logic [15:0]       win_x_i = '0, win_y_i = '0, win_w_i = '0, win_h_i = '0;
    logic              fb_rd_o, trmt_o, busy_o, done_o, err_o;
    logic [ADDR_W-1:0] fb_addr_o;
    logic [8*BPP-1:0]  fb_rdata_i;
    logic [7:0]        tx_data_o;

    int n_vec = 0, n_err = 0;
    int cyc = 0, rd_cnt = 0, done_cnt = 0, trmt_cnt = 0, bad_lat = 0, lat_seen = 0, rd_cyc = 0;
    bit rd_pend = 1'b0;
    logic [ADDR_W-1:0] addr_q[$];
    logic [7:0]        got[$];
    int                tcyc[$];
    logic              pv[0:LAT] = '{default: 1'b0};
    logic [23:0]       pd[0:LAT] = '{default: 24'h0};

    fb_window_streamer #(
        .H_RES(H_RES), .V_RES(V_RES), .BYTES_PER_PX(BPP), .FB_LATENCY(LAT), .ADDR_W(ADDR_W),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
        .win_x_i(win_x_i), .win_y_i(win_y_i), .win_w_i(win_w_i), .win_h_i(win_h_i),
        .fb_rd_o(fb_rd_o), .fb_addr_o(fb_addr_o), .fb_rdata_i(fb_rdata_i),
        .tx_data_o(tx_data_o), .trmt_o(trmt_o), .tx_done_i(tx_done_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pix(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_W'(0):    return 24'h010203;
            ADDR_W'(1):    return 24'h040506;
            ADDR_W'(1920): return 24'h070809;
            ADDR_W'(1921): return 24'h0A0B0C;
            default:       return {a[7:0], a[15:8], 8'h11};
        endcase
    endfunction

    // Frame buffer: data is valid only in the cycle exactly LAT after fb_rd.
    always @(negedge clk) begin
        for (int i = LAT; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = fb_rd_o;
        pd[0] = pix(fb_addr_o);
        fb_rdata_i = pv[LAT] ? pd[LAT] : 24'hEEEEEE;
        if (fb_rd_o) begin
            rd_cnt++;
            addr_q.push_back(fb_addr_o);
            rd_pend = 1'b1;
            rd_cyc  = cyc;
        end else if (trmt_o && rd_pend) begin
            lat_seen++;
            if (cyc - rd_cyc != LAT + 1) bad_lat++;
            rd_pend = 1'b0;
        end
        if (done_o) done_cnt++;
        if (trmt_o) trmt_cnt++;
    end

    task automatic do_start(input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] w, input logic [15:0] h);
        win_x_i = x; win_y_i = y; win_w_i = w; win_h_i = h;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // UART model: records each byte, answers tx_done D cycles after trmt.
    task automatic collect(input int stop_idx, input int abort_idx,
                           output bit timeout, output bit unstable);
        int budget;
        logic [7:0] b;
        budget = 0;
        got.delete();
        tcyc.delete();
        timeout  = 1'b0;
        unstable = 1'b0;
        while (1) begin
            if (budget > 5000) begin timeout = 1'b1; break; end
            if (done_o) break;
            if (trmt_o) begin
                b = tx_data_o;
                got.push_back(b);
                tcyc.push_back(cyc);
                if (got.size() - 1 == stop_idx) break;
                if (got.size() - 1 == abort_idx) abort_i = 1'b1;
                repeat (D) begin
                    @(negedge clk);
                    budget++;
                    if (tx_data_o !== b || trmt_o !== 1'b0) unstable = 1'b1;
                end
                tx_done_i = 1'b1;
                @(negedge clk);
                tx_done_i = 1'b0;
                budget++;
            end else begin
                @(negedge clk);
                budget++;
            end
        end
        abort_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_o, trmt_o, fb_rd_o, done_o, err_o, tx_data_o, fb_addr_o} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got busy=%b trmt=%b rd=%b done=%b err=%b data=%h addr=%h exp all 0",
                     busy_o, trmt_o, fb_rd_o, done_o, err_o, tx_data_o, fb_addr_o);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_o, trmt_o, fb_rd_o, done_o, err_o} !== 5'b0) begin
            n_err++;
            $display("FAIL post_reset_idle got %b exp 00000", {busy_o, trmt_o, fb_rd_o, done_o, err_o});
        end
    endtask

    task automatic test_2x2();
        logic [7:0]        exp[18] = '{8'hA5, 8'h02, 8'h00, 8'h02, 8'h00,
                                       8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                                       8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h4E};
        logic [ADDR_W-1:0] ea[4] = '{ADDR_W'(0), ADDR_W'(1), ADDR_W'(1920), ADDR_W'(1921)};
        int r0, a0, d0, bl0, ls0, end_cyc;
        bit to, un;
        r0 = rd_cnt; a0 = addr_q.size(); d0 = done_cnt; bl0 = bad_lat; ls0 = lat_seen;
        do_start(16'd0, 16'd0, 16'd2, 16'd2);
        n_vec++;
        if (busy_o !== 1'b1 || trmt_o !== 1'b1 || tx_data_o !== 8'hA5) begin
            n_err++;
            $display("FAIL 2x2_first_byte got busy=%b trmt=%b data=%h exp 1 1 a5", busy_o, trmt_o, tx_data_o);
        end
        collect(-1, -1, to, un);
        end_cyc = cyc;
        n_vec++;
        if (to !== 1'b0) begin n_err++; $display("FAIL 2x2_timeout got %b exp 0", to); end
        n_vec++;
        if (got.size() !== 18) begin n_err++; $display("FAIL 2x2_len got %0d exp 18", got.size()); end
        for (int k = 0; k < 18 && k < got.size(); k++) begin
            n_vec++;
            if (got[k] !== exp[k]) begin
                n_err++;
                $display("FAIL 2x2_byte%0d got %h exp %h", k, got[k], exp[k]);
            end
        end
        if (got.size() == 18) begin
            n_vec++;
            if (tcyc[1] - tcyc[0] !== D + 1) begin
                n_err++; $display("FAIL 2x2_hdr_gap got %0d exp %0d", tcyc[1] - tcyc[0], D + 1);
            end
            n_vec++;
            if (tcyc[5] - tcyc[4] !== D + 2 + LAT) begin
                n_err++; $display("FAIL 2x2_fetch_gap got %0d exp %0d", tcyc[5] - tcyc[4], D + 2 + LAT);
            end
            n_vec++;
            if (tcyc[17] - tcyc[16] !== D + 1) begin
                n_err++; $display("FAIL 2x2_cksum_gap got %0d exp %0d", tcyc[17] - tcyc[16], D + 1);
            end
            n_vec++;
            if (end_cyc - tcyc[17] !== D + 1) begin
                n_err++; $display("FAIL 2x2_done_time got %0d exp %0d", end_cyc - tcyc[17], D + 1);
            end
        end
        @(negedge clk);
        n_vec++;
        if (busy_o !== 1'b0) begin n_err++; $display("FAIL 2x2_busy_low got %b exp 0", busy_o); end
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL 2x2_done_cnt got %0d exp 1", done_cnt - d0); end
        n_vec++;
        if (rd_cnt - r0 !== 4) begin n_err++; $display("FAIL 2x2_rd_cnt got %0d exp 4", rd_cnt - r0); end
        for (int k = 0; k < 4 && a0 + k < addr_q.size(); k++) begin
            n_vec++;
            if (addr_q[a0+k] !== ea[k]) begin
                n_err++; $display("FAIL 2x2_addr%0d got %0d exp %0d", k, addr_q[a0+k], ea[k]);
            end
        end
        n_vec++;
        if (un !== 1'b0) begin n_err++; $display("FAIL 2x2_tx_stable got %b exp 0", un); end
        n_vec++;
        if (lat_seen - ls0 !== 4 || bad_lat !== bl0) begin
            n_err++;
            $display("FAIL 2x2_latency got seen=%0d bad=%0d exp seen=4 bad=0", lat_seen - ls0, bad_lat - bl0);
        end
    endtask

    task automatic test_empty();
        logic [7:0] exp[6] = '{8'hA5, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00};
        int r0, d0;
        bit to, un;
        r0 = rd_cnt; d0 = done_cnt;
        do_start(16'd3, 16'd4, 16'd0, 16'd5);
        collect(-1, -1, to, un);
        @(negedge clk);
        n_vec++;
        if (to !== 1'b0 || got.size() !== 6) begin
            n_err++; $display("FAIL empty_len got %0d timeout=%b exp 6", got.size(), to);
        end
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_vec++;
            if (got[k] !== exp[k]) begin
                n_err++; $display("FAIL empty_byte%0d got %h exp %h", k, got[k], exp[k]);
            end
        end
        n_vec++;
        if (rd_cnt - r0 !== 0) begin n_err++; $display("FAIL empty_no_rd got %0d exp 0", rd_cnt - r0); end
        n_vec++;
        if (done_cnt - d0 !== 1) begin n_err++; $display("FAIL empty_done got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_reject();
        logic [7:0] exp[12] = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h00,
                                8'h7E, 8'h07, 8'h11, 8'h7F, 8'h07, 8'h11, 8'h2D};
        int t0, r0, a0;
        bit to, un;
        t0 = trmt_cnt;
        do_start(16'd1919, 16'd0, 16'd2, 16'd1);
        n_vec++;
        if (err_o !== 1'b1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL reject_x got err=%b busy=%b exp 1 0", err_o, busy_o);
        end
        @(negedge clk);
        n_vec++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL reject_err_pulse got %b exp 0", err_o); end
        do_start(16'd0, 16'd1076, 16'd1, 16'd5);
        n_vec++;
        if (err_o !== 1'b1) begin n_err++; $display("FAIL reject_y got %b exp 1", err_o); end
        repeat (5) @(negedge clk);
        n_vec++;
        if (trmt_cnt - t0 !== 0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL reject_silent got trmt=%0d busy=%b exp 0 0", trmt_cnt - t0, busy_o);
        end
        r0 = rd_cnt; a0 = addr_q.size();
        do_start(16'd1918, 16'd0, 16'd2, 16'd1);
        n_vec++;
        if (err_o !== 1'b0 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL edge_accept got err=%b busy=%b exp 0 1", err_o, busy_o);
        end
        collect(-1, -1, to, un);
        n_vec++;
        if (to !== 1'b0 || got.size() !== 12) begin
            n_err++; $display("FAIL edge_len got %0d timeout=%b exp 12", got.size(), to);
        end
        for (int k = 0; k < 12 && k < got.size(); k++) begin
            n_vec++;
            if (got[k] !== exp[k]) begin
                n_err++; $display("FAIL edge_byte%0d got %h exp %h", k, got[k], exp[k]);
            end
        end
        n_vec++;
        if (rd_cnt - r0 !== 2 || addr_q.size() != a0 + 2 || addr_q[addr_q.size()-1] !== ADDR_W'(1919)) begin
            n_err++;
            $display("FAIL edge_addr got reads=%0d last=%0d exp 2 1919", rd_cnt - r0, addr_q[addr_q.size()-1]);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        int d0;
        bit to, un;
        d0 = done_cnt;
        do_start(16'd0, 16'd0, 16'd2, 16'd2);
        collect(-1, 6, to, un);
        @(negedge clk);
        n_vec++;
        if (to !== 1'b0 || got.size() !== 7) begin
            n_err++; $display("FAIL abort_len got %0d timeout=%b exp 7", got.size(), to);
        end
        n_vec++;
        if (got.size() >= 7 && (got[5] !== 8'h01 || got[6] !== 8'h02)) begin
            n_err++; $display("FAIL abort_bytes got %h %h exp 01 02", got[5], got[6]);
        end
        n_vec++;
        if (done_cnt - d0 !== 1 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL abort_done got done=%0d busy=%b exp 1 0", done_cnt - d0, busy_o);
        end
        do_start(16'd1918, 16'd0, 16'd2, 16'd1);
        collect(-1, -1, to, un);
        n_vec++;
        if (to !== 1'b0 || got.size() !== 12 || got[0] !== 8'hA5 || got[11] !== 8'h2D) begin
            n_err++;
            $display("FAIL abort_restart got len=%0d first=%h last=%h exp 12 a5 2d",
                     got.size(), got[0], got[got.size()-1]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to, un;
        do_start(16'd0, 16'd0, 16'd2, 16'd2);
        collect(7, -1, to, un);
        rst_i = 1'b1;
        #1;
        n_vec++;
        if (to !== 1'b0 || {busy_o, trmt_o, fb_rd_o, done_o, err_o, tx_data_o, fb_addr_o} !== '0) begin
            n_err++;
            $display("FAIL midrst_outputs got busy=%b trmt=%b rd=%b done=%b err=%b data=%h addr=%h exp all 0",
                     busy_o, trmt_o, fb_rd_o, done_o, err_o, tx_data_o, fb_addr_o);
        end
        @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (trmt_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL midrst_quiet got trmt=%b busy=%b exp 0 0", trmt_o, busy_o);
        end
        do_start(16'd0, 16'd0, 16'd2, 16'd2);
        collect(-1, -1, to, un);
        n_vec++;
        if (to !== 1'b0 || got.size() !== 18 || got[0] !== 8'hA5 || got[17] !== 8'h4E) begin
            n_err++;
            $display("FAIL midrst_restart got len=%0d first=%h last=%h exp 18 a5 4e",
                     got.size(), got[0], got[got.size()-1]);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_2x2();
        test_empty();
        test_reject();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fb_window_streamer.md
# fb_window_streamer

Parametrised successor to the frame-buffer UART transmitter. It streams a rectangular window of the frame buffer, rather than the whole frame, to the host over the existing UART byte interface. Each stream is a framed packet: header, pixel bytes, then a checksum trailer. The pixel width, frame dimensions and frame-buffer read latency are parameters. It sits between the frame buffer read port and the shared UART transmitter, and is started by the drawing pipeline's completion or by a host command.

## Interface
- H_RES, 1920: frame width in pixels.
- V_RES, 1080: frame height in pixels.
- BYTES_PER_PX, 3: bytes per pixel (1..4), sent MSB-first.
- FB_LATENCY, 1: cycles from `fb_rd` to valid `fb_rdata` (1..4).
- ADDR_W, $clog2(H_RES*V_RES): frame-buffer address width.
- SYNC_BYTE, 8'hA5: packet start marker.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- abort  in  1  level; stops the stream at the next byte boundary.
- win_x, win_y  in  16 each  window origin; latched on accepted start.
- win_w, win_h  in  16 each  window size; latched on accepted start.
- fb_rd  out  1  frame-buffer read strobe, one cycle per pixel.
- fb_addr  out  ADDR_W  read address, (win_y+row)*H_RES + win_x + col.
- fb_rdata  in  8*BYTES_PER_PX  pixel data.
- tx_data  out  8  byte to UART.
- trmt  out  1  one-cycle transmit request.
- tx_done  in  1  one-cycle pulse when UART finishes the byte.
- busy  out  1  high from accepted start until DONE.
- done  out  1  one-cycle pulse at end of packet or abort.
- err  out  1  one-cycle pulse on rejected start.

## Operation
- Reset values: every output is 0, the state is IDLE and all counters are 0.
- Packet layout, in order:
  - SYNC_BYTE;
  - win_w[7:0], win_w[15:8], win_h[7:0], win_h[15:8];
  - win_w*win_h pixels, row-major, each as BYTES_PER_PX bytes MSB-first;
  - checksum byte.
- Checksum: 8-bit sum mod 256 of the pixel bytes only (header excluded).
- A start is rejected with an `err` pulse, and no packet is sent, if win_x+win_w > H_RES or win_y+win_h > V_RES. Compute the sums at 17 bits.
- States:
  - IDLE: an accepted start moves to HDR.
  - HDR: sends 5 bytes. Then goes to FETCH, or to CKSUM if win_w==0 or win_h==0.
  - FETCH: asserts `fb_rd`, moves to WAIT_RD.
  - WAIT_RD: waits FB_LATENCY cycles, captures `fb_rdata` into the shift register, moves to SEND_PX.
  - SEND_PX: sends BYTES_PER_PX bytes. After the last byte of the last pixel it goes to CKSUM, otherwise back to FETCH.
  - CKSUM: sends the checksum byte, then goes to DONE.
  - DONE: pulses `done`, returns to IDLE.
- Address generation:
  - col increments per pixel.
  - When col reaches win_w-1, col wraps to 0, row increments and row_base += H_RES.
  - No multiplier in the per-pixel path: the one product win_y*H_RES is formed on start.
- Handshake: `tx_data` is stable from `trmt` until `tx_done`. Only one byte is outstanding at a time.
- Abort: honoured at the next `tx_done` (or immediately if no byte is outstanding). The block then goes to DONE without sending the checksum.
- A start while busy is ignored, with no `err`.
- Asserting `rst` mid-packet clears everything immediately. No partial byte is re-sent after reset.

## Timing
- An accepted start at cycle N gives `trmt` with 0xA5 at N+1, and `busy` high from N+1.
- After `tx_done` at cycle T, the next `trmt` is at T+1 for header, pixel and checksum bytes within a phase.
- After `tx_done` of the last header byte or last pixel byte at T: `fb_rd` at T+1, capture at T+1+FB_LATENCY, `trmt` at T+2+FB_LATENCY.
- After `tx_done` of the checksum at T: `done` at T+1, `busy` low at T+2.
- `err` is asserted one cycle after start.

## Structure
- Package `fb_stream_pkg`: state enum `fbs_state_t` plus the HDR_BYTES=5 and default SYNC_BYTE constants.
- Sub-module `fb_window_addr_gen`: col/row counters, row_base accumulator, `fb_addr`, and `last_px` flag. It has `load`/`step` inputs.
- Top level: the FSM, the byte/shift counter, latency counter, checksum accumulator and header mux.

## Test plan
- 2x2 window at (0,0), BYTES_PER_PX=3, pixels 0x010203, 0x040506, 0x070809, 0x0A0B0C -> bytes A5 02 00 02 00, the 12 pixel bytes, then checksum 0x4E. `fb_addr` sequence is 0, 1, 1920, 1921.
- win_w=0, win_h=5 -> bytes A5 00 00 05 00 00, no `fb_rd`, one `done` pulse.
- win_x=1919, win_w=2 -> `err` pulse, no `trmt`, `busy` stays 0. Then win_x=1918, win_w=2 is accepted, last `fb_addr` is 1919 for one row.
- FB_LATENCY=3 with `tx_done` returned 10 cycles after each `trmt` -> capture exactly 3 cycles after `fb_rd`. `tx_data` is stable throughout each byte.
- `abort` raised during the second pixel byte -> that byte completes, no checksum byte is sent, `done` pulses, and a new start is accepted afterward.
- `rst` asserted mid-SEND_PX -> all outputs 0 on the same edge. The next start emits a full packet beginning with A5.
